// File: rtl/vending_machine_param.sv
// Parametrised vending controller: configurable items/prices, per-item stock with
// sold-out flags, cancel/refund, credit overflow protection and serial change return.
module vending_machine_param #(
  parameter int unsigned                   NUM_ITEMS  = 4,
  parameter int unsigned                   ITEM_W     = 2,
  parameter int unsigned                   PRICE_W    = 4,
  parameter logic [NUM_ITEMS*PRICE_W-1:0]  PRICES     = 16'h8532,
  parameter int unsigned                   CREDIT_W   = 6,
  parameter int unsigned                   STOCK_W    = 3,
  parameter int unsigned                   STOCK_INIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ITEM_W-1:0]    item,
  input  logic                 sel,
  input  logic                 dollar_10,
  input  logic                 dollar_50,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [PRICE_W-1:0]   price,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] item_rels,
  output logic                 change_return,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 coin_reject,
  output logic                 sel_reject
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAY,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam int unsigned            SUM_W      = CREDIT_W + 3;
  localparam logic [SUM_W-1:0]       CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});
  localparam logic [STOCK_W-1:0]     STOCK_LOAD = STOCK_W'(STOCK_INIT);

  state_t                                 r_state, w_state_nxt;
  logic [ITEM_W-1:0]                      r_item, w_item_nxt;
  logic [PRICE_W-1:0]                     r_price, w_price_nxt;
  logic [CREDIT_W-1:0]                    r_credit, w_credit_nxt;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]      r_stock, w_stock_nxt;
  logic [NUM_ITEMS-1:0]                   r_item_rels, w_rels_nxt;
  logic [NUM_ITEMS-1:0]                   r_sold_out, w_sold_nxt;
  logic                                   r_change_return, w_change_nxt;
  logic                                   r_coin_reject, w_coin_rej_nxt;
  logic                                   r_sel_reject, w_sel_rej_nxt;

  logic                                   w_coin_any;
  logic [2:0]                             w_inc;
  logic [SUM_W-1:0]                       w_sum;
  logic [CREDIT_W-1:0]                    w_remain;
  logic                                   w_sel_ok;
  logic [PRICE_W-1:0]                     w_sel_price;

  assign w_coin_any = dollar_10 | dollar_50;
  assign w_inc      = {dollar_50, 1'b0, dollar_50} + {2'b00, dollar_10};
  assign w_sum      = SUM_W'(r_credit) + SUM_W'(w_inc);
  assign w_remain   = CREDIT_W'(32'(r_credit) - 32'(r_price));

  // Decode the requested item without a range compare so any NUM_ITEMS works;
  // an index with no matching item simply never qualifies.
  always_comb begin
    w_sel_ok    = 1'b0;
    w_sel_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (item == ITEM_W'(i)) begin
        w_sel_ok    = (r_stock[i] != '0);
        w_sel_price = PRICES[i*PRICE_W +: PRICE_W];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_item_nxt     = r_item;
    w_price_nxt    = r_price;
    w_credit_nxt   = r_credit;
    w_stock_nxt    = r_stock;
    w_rels_nxt     = '0;
    w_coin_rej_nxt = 1'b0;
    w_sel_rej_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_coin_rej_nxt = w_coin_any;
        if (restock) begin
          for (int unsigned i = 0; i < NUM_ITEMS; i++) w_stock_nxt[i] = STOCK_LOAD;
        end
        if (sel) begin
          if (w_sel_ok) begin
            w_item_nxt  = item;
            w_price_nxt = w_sel_price;
            w_state_nxt = S_PAY;
          end else begin
            w_sel_rej_nxt = 1'b1;
          end
        end
      end

      S_PAY: begin
        w_sel_rej_nxt = sel;
        if (w_sum > CREDIT_MAX) w_coin_rej_nxt = 1'b1;
        else                    w_credit_nxt   = w_sum[CREDIT_W-1:0];
        // Cancel wins over a paying coin: the coin is kept in credit and refunded.
        if (cancel) begin
          w_price_nxt = '0;
          w_state_nxt = (w_credit_nxt != '0) ? S_CHANGE : S_IDLE;
        end else if (32'(w_credit_nxt) >= 32'(r_price)) begin
          w_state_nxt = S_VEND;
          w_rels_nxt  = NUM_ITEMS'(1) << r_item;
        end
      end

      S_VEND: begin
        w_coin_rej_nxt       = w_coin_any;
        w_sel_rej_nxt        = sel;
        w_credit_nxt         = w_remain;
        w_price_nxt          = '0;
        w_stock_nxt[r_item]  = r_stock[r_item] - STOCK_W'(1);
        w_state_nxt          = (w_remain != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        w_coin_rej_nxt = w_coin_any;
        w_sel_rej_nxt  = sel;
        if (r_credit <= CREDIT_W'(1)) begin
          w_credit_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_credit_nxt = r_credit - CREDIT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_change_nxt = (w_state_nxt == S_CHANGE);
    for (int unsigned i = 0; i < NUM_ITEMS; i++) w_sold_nxt[i] = (w_stock_nxt[i] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_item          <= '0;
      r_price         <= '0;
      r_credit        <= '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_LOAD;
      r_item_rels     <= '0;
      r_sold_out      <= '0;
      r_change_return <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_sel_reject    <= 1'b0;
    end else begin
      r_item          <= w_item_nxt;
      r_price         <= w_price_nxt;
      r_credit        <= w_credit_nxt;
      r_stock         <= w_stock_nxt;
      r_item_rels     <= w_rels_nxt;
      r_sold_out      <= w_sold_nxt;
      r_change_return <= w_change_nxt;
      r_coin_reject   <= w_coin_rej_nxt;
      r_sel_reject    <= w_sel_rej_nxt;
    end
  end

  assign price         = r_price;
  assign credit        = r_credit;
  assign item_rels     = r_item_rels;
  assign change_return = r_change_return;
  assign sold_out      = r_sold_out;
  assign coin_reject   = r_coin_reject;
  assign sel_reject    = r_sel_reject;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default instance plus a CREDIT_W=3
// instance sharing the same stimulus for the credit overflow case.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] item = '0;
  logic       sel = 1'b0, dollar_10 = 1'b0, dollar_50 = 1'b0, cancel = 1'b0, restock = 1'b0;

  logic [3:0] price,  price3;
  logic [5:0] credit;
  logic [2:0] credit3;
  logic [3:0] item_rels, item_rels3, sold_out, sold_out3;
  logic       change_return, change_return3, coin_reject, coin_reject3, sel_reject, sel_reject3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vending_machine_param u_dut (
    .clk(clk), .reset(reset), .item(item), .sel(sel), .dollar_10(dollar_10),
    .dollar_50(dollar_50), .cancel(cancel), .restock(restock), .price(price),
    .credit(credit), .item_rels(item_rels), .change_return(change_return),
    .sold_out(sold_out), .coin_reject(coin_reject), .sel_reject(sel_reject)
  );

  vending_machine_param #(.CREDIT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .item(item), .sel(sel), .dollar_10(dollar_10),
    .dollar_50(dollar_50), .cancel(cancel), .restock(restock), .price(price3),
    .credit(credit3), .item_rels(item_rels3), .change_return(change_return3),
    .sold_out(sold_out3), .coin_reject(coin_reject3), .sel_reject(sel_reject3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic select(input logic [1:0] idx);
    sel  = 1'b1;
    item = idx;
    step();
    sel  = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_credit", 32'(credit), 0);
    check("rst_price", 32'(price), 0);
    check("rst_rels", 32'(item_rels), 0);
    check("rst_chg", 32'(change_return), 0);
    check("rst_sold", 32'(sold_out), 0);
    check("rst_rej", 32'({coin_reject, sel_reject}), 0);

    // Exact pay, item 1 price 3
    select(2'd1);
    check("ex_price", 32'(price), 3);
    dollar_10 = 1'b1;
    step(); check("ex_cr1", 32'(credit), 1); check("ex_chg1", 32'(change_return), 0);
    step(); check("ex_cr2", 32'(credit), 2);
    step(); dollar_10 = 1'b0;
    check("ex_cr3", 32'(credit), 3);
    check("ex_rels", 32'(item_rels), 32'h2);
    check("ex_chg3", 32'(change_return), 0);
    step();
    check("ex_cr_end", 32'(credit), 0);
    check("ex_rels_end", 32'(item_rels), 0);
    check("ex_price_end", 32'(price), 0);
    check("ex_chg_end", 32'(change_return), 0);
    check("ex_stock1", 32'(u_dut.r_stock[1]), 2);

    // Overpay item 0 (price 2) with $50 -> change 3
    select(2'd0);
    check("op_price", 32'(price), 2);
    dollar_50 = 1'b1; step(); dollar_50 = 1'b0;
    check("op_cr", 32'(credit), 5);
    check("op_rels", 32'(item_rels), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("op_chg", 32'(change_return), 1);
      check("op_crdn", 32'(credit), 32'(3 - i));
      check("op_rels0", 32'(item_rels), 0);
    end
    step();
    check("op_chg_end", 32'(change_return), 0);
    check("op_cr_end", 32'(credit), 0);

    // Cancel after +6 on item 3
    select(2'd3);
    check("cn_price", 32'(price), 8);
    dollar_10 = 1'b1; dollar_50 = 1'b1; step(); dollar_10 = 1'b0; dollar_50 = 1'b0;
    check("cn_cr6", 32'(credit), 6);
    check("cn_rej", 32'(coin_reject), 0);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("cn_price0", 32'(price), 0);
    for (int i = 0; i < 6; i++) begin
      check("cn_chg", 32'(change_return), 1);
      check("cn_crdn", 32'(credit), 32'(6 - i));
      check("cn_rels", 32'(item_rels), 0);
      step();
    end
    check("cn_chg_end", 32'(change_return), 0);
    check("cn_cr_end", 32'(credit), 0);
    check("cn_stock3", 32'(u_dut.r_stock[3]), 3);

    // Sold out item 2 after three buys
    for (int n = 0; n < 3; n++) begin
      select(2'd2);
      check("so_price", 32'(price), 5);
      dollar_50 = 1'b1; step(); dollar_50 = 1'b0;
      check("so_rels", 32'(item_rels), 32'h4);
      step();
      check("so_cr0", 32'(credit), 0);
    end
    check("so_flags", 32'(sold_out), 32'h4);
    select(2'd2);
    check("so_selrej", 32'(sel_reject), 1);
    check("so_idle_price", 32'(price), 0);
    step();
    check("so_selrej_pulse", 32'(sel_reject), 0);

    // Coin in IDLE rejected
    dollar_10 = 1'b1; step(); dollar_10 = 1'b0;
    check("idle_coinrej", 32'(coin_reject), 1);
    check("idle_credit", 32'(credit), 0);
    step();
    check("idle_coinrej_pulse", 32'(coin_reject), 0);

    // Restock and buy item 2 again; sel during PAY is refused
    restock = 1'b1; step(); restock = 1'b0;
    check("rs_flags", 32'(sold_out), 0);
    select(2'd2);
    check("rs_price", 32'(price), 5);
    select(2'd0);
    check("pay_selrej", 32'(sel_reject), 1);
    check("pay_price_kept", 32'(price), 5);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("cn0_price", 32'(price), 0);
    check("cn0_chg", 32'(change_return), 0);
    check("cn0_credit", 32'(credit), 0);

    // Overflow on the CREDIT_W=3 instance
    do_reset();
    select(2'd3);
    check("ov_price", 32'(price3), 8);
    dollar_50 = 1'b1; step();
    check("ov_cr5", 32'(credit3), 5);
    check("ov_norej", 32'(coin_reject3), 0);
    step(); dollar_50 = 1'b0;
    check("ov_rej", 32'(coin_reject3), 1);
    check("ov_cr_kept", 32'(credit3), 5);
    check("ov_wide_cr", 32'(credit), 10);
    check("ov_wide_rels", 32'(item_rels), 32'h8);

    // Reset during refund of credit 4
    do_reset();
    select(2'd0);
    dollar_10 = 1'b1; dollar_50 = 1'b1; step(); dollar_10 = 1'b0; dollar_50 = 1'b0;
    check("rm_cr6", 32'(credit), 6);
    step();
    check("rm_chg1", 32'(change_return), 1);
    check("rm_cr4", 32'(credit), 4);
    step();
    check("rm_cr3", 32'(credit), 3);
    reset = 1'b1; step(); reset = 1'b0;
    check("rm_credit", 32'(credit), 0);
    check("rm_chg", 32'(change_return), 0);
    check("rm_price", 32'(price), 0);
    check("rm_rels", 32'(item_rels), 0);
    check("rm_sold", 32'(sold_out), 0);
    check("rm_stock0", 32'(u_dut.r_stock[0]), 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the team's fixed 4-item vending controller.
- Adds a configurable item count and per-item prices, per-item stock tracking with sold-out flags, cancel/refund, credit overflow protection, and serial change dispensing (one $10 coin per cycle).
- Sits between the coin/selection front panel and the dispenser/coin-return actuators.
- All money is counted in units of $10.

Parameters:
NUM_ITEMS, 4, number of selectable items (≥2)
ITEM_W, 2, width of item index, = clog2(NUM_ITEMS)
PRICE_W, 4, width of one price field
PRICES, 16'h8532, packed prices; item i = PRICES[i*PRICE_W +: PRICE_W] (defaults: item0=2, item1=3, item2=5, item3=8); each must be nonzero
CREDIT_W, 6, credit register width; max credit = 2^CREDIT_W-1
STOCK_W, 3, width of each stock counter
STOCK_INIT, 3, stock loaded per item at reset/restock

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
item  in  ITEM_W  item index, sampled with sel
sel  in  1  select strobe
dollar_10  in  1  $10 coin strobe (+1 credit)
dollar_50  in  1  $50 coin strobe (+5 credit)
cancel  in  1  abort purchase, refund credit
restock  in  1  reload all stock counters
price  out  PRICE_W  price of latched item; 0 outside PAY/VEND
credit  out  CREDIT_W  current credit
item_rels  out  NUM_ITEMS  one-hot release pulse
change_return  out  1  one $10 coin returned per high cycle
sold_out  out  NUM_ITEMS  level; bit i = (stock[i]==0)
coin_reject  out  1  pulse; coin(s) not accepted
sel_reject  out  1  pulse; selection refused

Behaviour:
- Reset: state IDLE; credit=0; price=0; item_rels=0; change_return=0; coin_reject=0; sel_reject=0; every stock=STOCK_INIT; sold_out=0. Reset applies mid-operation and discards credit with no refund.
- All outputs are registered. Pulses last exactly one cycle.
- IDLE:
  - sel with stock[item]>0: latch item, price<=PRICES[item], go to PAY.
  - sel with stock[item]==0, or item≥NUM_ITEMS: sel_reject pulse, stay in IDLE.
  - Coins: coin_reject pulse, credit unchanged.
  - restock: all stock<=STOCK_INIT. restock is ignored in every other state.
- PAY:
  - Coin increment = dollar_10 + 5·dollar_50 (both high = +6).
  - If credit+increment > 2^CREDIT_W-1: reject the whole increment (coin_reject pulse), credit unchanged.
  - Otherwise credit<=credit+increment.
  - Next state uses the post-add credit: cancel → CHANGE if credit>0, else IDLE; otherwise credit≥price → VEND; otherwise stay.
  - cancel beats a coin that reaches the price in the same cycle: the coin is accepted, then fully refunded.
  - sel in PAY: sel_reject pulse; the latched item is unchanged.
- VEND (exactly 1 cycle):
  - item_rels = one-hot(latched item) during this cycle.
  - On exit edge: stock[item]--, credit<=credit-price, price<=0.
  - Next state: CHANGE if the remainder >0, else IDLE.
  - Coins and sel: reject pulses. cancel is ignored.
- CHANGE:
  - change_return=1 every cycle in this state; credit decrements by 1 per edge.
  - Exit to IDLE on the edge where credit reaches 0. change_return is high for exactly the refunded credit count of cycles.
  - Coins and sel: reject pulses. cancel is ignored.
- price is 0 when leaving for IDLE or CHANGE. Stock never underflows, because sel is gated by stock>0.
- Latency: sel → PAY is 1 cycle. Paying coin edge → VEND is the next cycle. VEND → first change_return is the following cycle.

Test Plan:
- Exact pay: reset; sel item=1 → price=3. Three dollar_10 strobes → credit 1,2,3, then one cycle with item_rels=4'b0010, then IDLE with credit=0, change_return never high, stock1=2.
- Overpay with change: sel item=0 (price 2); one dollar_50 → credit=5, VEND with item_rels=4'b0001, then change_return high 3 consecutive cycles, credit 3→0, back to IDLE.
- Cancel: sel item=3 (price 8); dollar_10 + dollar_50 same cycle → credit=6; cancel → change_return high 6 cycles, no item_rels, stock3 unchanged.
- Sold out/restock: buy item 2 three times (price 5 each) → sold_out=4'b0100; next sel item=2 → sel_reject pulse, stays in IDLE; restock → sold_out=0 and item 2 is purchasable again.
- Overflow/rejects: with CREDIT_W=3 and item 3 selected (price 8, unreachable), credit=5 then dollar_50 → coin_reject, credit stays 5; coin in IDLE → coin_reject; sel during PAY → sel_reject, price unchanged.
- Reset mid-CHANGE: during refund of credit 4, assert reset after 2 change_return cycles → next cycle all outputs at reset values, stocks=STOCK_INIT.
